// File: rtl/ss_sweep_master.sv
// Save-state sweep master: walks mapper save-state registers 0..LAST_ADDR,
// copying them into a buffer (save) or restoring them from it (load).
module ss_sweep_master #(
    parameter int LAST_ADDR = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_save,
    input  logic       start_load,
    input  logic       abort,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    output logic       ss_m2,
    input  logic [7:0] ss_rdat,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_wdat,
    output logic       buf_we,
    input  logic [7:0] buf_rdat,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [7:0] LAST = 8'(LAST_ADDR);

    logic [2:0] state_q, state_d;
    logic       load_q, load_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdat_q, wdat_d;
    logic       act_q, act_d;
    logic       we_q, we_d;
    logic       m2_q, m2_d;
    logic       bwe_q, bwe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_save || start_load) begin
                        state_d = S_SETUP;
                        addr_d  = 8'd0;
                        load_d  = !start_save;
                    end
                end
                S_SETUP: state_d = S_SAMPLE;
                S_SAMPLE: begin
                    state_d = S_STROBE;
                    if (load_q) wdat_d = buf_rdat;
                end
                S_STROBE: state_d = S_NEXT;
                S_NEXT: begin
                    // Compare before incrementing so LAST=255 never wraps
                    if (addr_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        addr_d  = addr_q + 8'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobe outputs are registered from the next state to stay glitch-free
    always_comb begin
        act_d  = (state_d == S_SETUP) || (state_d == S_SAMPLE) ||
                 (state_d == S_STROBE) || (state_d == S_NEXT);
        m2_d   = !((state_d == S_STROBE) || (state_d == S_NEXT));
        we_d   = load_d &&
                 ((state_d == S_SAMPLE) || (state_d == S_STROBE));
        bwe_d  = !load_d && (state_d == S_SAMPLE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            addr_q  <= 8'd0;
            wdat_q  <= 8'd0;
            act_q   <= 1'b0;
            we_q    <= 1'b0;
            m2_q    <= 1'b1;
            bwe_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            act_q   <= act_d;
            we_q    <= we_d;
            m2_q    <= m2_d;
            bwe_q   <= bwe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // In load SAMPLE the buffer data passes straight through; the same value
    // is captured on the M2 falling edge, so the bus is stable across it.
    assign ss_wdat  = (state_q == S_SAMPLE && load_q) ? buf_rdat : wdat_q;
    assign ss_act   = act_q;
    assign ss_we    = we_q;
    assign ss_m2    = m2_q;
    assign ss_addr  = addr_q;
    assign buf_addr = addr_q;
    assign buf_wdat = ss_rdat;
    assign buf_we   = bwe_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ss_sweep_master.sv
// Randomized bench for ss_sweep_master: three instances (LAST_ADDR 2/127/255)
// with mapper and buffer models, checked against sweep-level expectations.
module tb_ss_sweep_master;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic       st_s[N], st_l[N], ab[N];
    logic       act[N], we[N], m2[N], bwe[N], busy[N], done[N];
    logic [7:0] addr[N], wdat[N], rdat[N];
    logic [7:0] baddr[N], bwdat[N], brdat[N];

    logic [7:0] mapr[N][256];
    logic [7:0] mapw[N][256];
    logic [7:0] bufr[N][256];
    logic [7:0] bufw[N][256];

    int bwe_n[N], mw_n[N], we_hi[N], done_n[N], done_at[N];
    int stab_err[N], wrap_n[N];
    logic       pm2[N], pwe[N], pbusy[N];
    logic [7:0] pwdat[N], paddr[N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int last_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 127 : 255;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_i
        ss_sweep_master #(.LAST_ADDR(last_of(g))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_save(st_s[g]),
            .start_load(st_l[g]),
            .abort     (ab[g]),
            .ss_act    (act[g]),
            .ss_we     (we[g]),
            .ss_addr   (addr[g]),
            .ss_wdat   (wdat[g]),
            .ss_m2     (m2[g]),
            .ss_rdat   (rdat[g]),
            .buf_addr  (baddr[g]),
            .buf_wdat  (bwdat[g]),
            .buf_we    (bwe[g]),
            .buf_rdat  (brdat[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
        assign rdat[g] = mapr[g][addr[g]];
    end

    // Buffer: synchronous write, one-clk read latency
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (bwe[g]) bufw[g][baddr[g]] <= bwdat[g];
            brdat[g] <= bufr[g][baddr[g]];
        end
    end

    // Mapper: commits a write on each M2 falling edge with ss_we high
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (bwe[g]) bwe_n[g]++;
            if (we[g]) we_hi[g]++;
            if (done[g]) begin
                done_n[g]++;
                done_at[g] = cyc;
            end
            if (pm2[g] === 1'b1 && m2[g] === 1'b0) begin
                if (we[g]) begin
                    mapw[g][addr[g]] = wdat[g];
                    mw_n[g]++;
                end
                if (pwe[g] !== we[g] || pwdat[g] !== wdat[g])
                    stab_err[g]++;
            end
            if (pbusy[g] === 1'b1 && busy[g] === 1'b1 &&
                paddr[g] != 8'd0 && addr[g] == 8'd0)
                wrap_n[g]++;
            pm2[g]   = m2[g];
            pwe[g]   = we[g];
            pwdat[g] = wdat[g];
            paddr[g] = addr[g];
            pbusy[g] = busy[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int g, input int d0, input int lim,
                             input string tag);
        int n = 0;
        while (done_n[g] == d0 && n < lim) begin
            tick;
            n++;
        end
        chk({tag, ".tmo"}, 32'(done_n[g] != d0), 32'd1);
    endtask

    task automatic fill_rand(input int g);
        for (int a = 0; a < 256; a++) begin
            mapr[g][a] = 8'($urandom);
            bufr[g][a] = 8'($urandom);
        end
    endtask

    task automatic sweep(input int g, input bit ld, input bit both,
                         input bit poke, input string tag);
        int L = last_of(g);
        int acc, err;
        int d0 = done_n[g];
        int b0 = bwe_n[g];
        int w0 = we_hi[g];
        int m0 = mw_n[g];
        int s0 = stab_err[g];
        int r0 = wrap_n[g];
        st_s[g] = !ld || both;
        st_l[g] = ld || both;
        tick;
        acc = cyc;
        st_s[g] = 1'b0;
        st_l[g] = 1'b0;
        chk({tag, ".a0"}, {busy[g], act[g], addr[g]}, {2'b11, 8'h00});
        if (poke) begin
            repeat (3) tick;
            if (ld) st_s[g] = 1'b1;
            else st_l[g] = 1'b1;
            tick;
            st_s[g] = 1'b0;
            st_l[g] = 1'b0;
        end
        wait_done(g, d0, 4 * (L + 1) + 20, tag);
        repeat (2) tick;
        err = 0;
        for (int a = 0; a <= L; a++) begin
            if (ld ? (mapw[g][a] !== bufr[g][a])
                   : (bufw[g][a] !== mapr[g][a])) err++;
        end
        chk({tag, ".data"}, err, 0);
        chk({tag, ".nwr"}, ld ? mw_n[g] - m0 : bwe_n[g] - b0, L + 1);
        chk({tag, ".xwr"}, ld ? bwe_n[g] - b0 : we_hi[g] - w0, 0);
        chk({tag, ".done"}, done_n[g] - d0, 1);
        chk({tag, ".lat"}, done_at[g] - acc + 1, 4 * (L + 1) + 1);
        chk({tag, ".stab"}, stab_err[g] - s0, 0);
        chk({tag, ".wrap"}, wrap_n[g] - r0, 0);
        chk({tag, ".fin"}, {busy[g], addr[g]}, {1'b0, 8'(L)});
    endtask

    initial begin
        int d0, m0, b0, w0, n;
        for (int g = 0; g < N; g++) begin
            st_s[g] = 1'b0;
            st_l[g] = 1'b0;
            ab[g]   = 1'b0;
        end
        #1 rst_n = 1'b0;
        tick;
        tick;
        for (int g = 0; g < N; g++)
            chk($sformatf("rst%0d", g),
                {act[g], we[g], m2[g], addr[g], wdat[g], bwe[g], busy[g],
                 done[g]},
                {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        tick;

        for (int g = 0; g < N; g++) fill_rand(g);

        mapr[0][0] = 8'h05;
        mapr[0][1] = 8'h0A;
        mapr[0][2] = 8'h01;
        sweep(0, 1'b0, 1'b0, 1'b0, "save3");
        chk("save3.buf", {bufw[0][0], bufw[0][1], bufw[0][2]}, 24'h050A01);

        bufr[0][0] = 8'hF3;
        bufr[0][1] = 8'h07;
        bufr[0][2] = 8'h01;
        sweep(0, 1'b1, 1'b0, 1'b0, "load3");
        chk("load3.map", {mapw[0][0], mapw[0][1], mapw[0][2]}, 24'hF30701);

        fill_rand(0);
        sweep(0, 1'b0, 1'b1, 1'b1, "both");

        fill_rand(0);
        d0 = done_n[0];
        m0 = mw_n[0];
        b0 = bwe_n[0];
        w0 = we_hi[0];
        st_l[0] = 1'b1;
        tick;
        st_l[0] = 1'b0;
        n = 0;
        while (!(m2[0] == 1'b0 && addr[0] == 8'd1) && n < 50) begin
            tick;
            n++;
        end
        chk("abort.reach", 32'(n < 50), 32'd1);
        ab[0] = 1'b1;
        tick;
        ab[0] = 1'b0;
        chk("abort.out", {act[0], we[0], m2[0], bwe[0], busy[0], done[0]},
            6'b001000);
        repeat (20) tick;
        chk("abort.done", done_n[0] - d0, 0);
        chk("abort.mw", mw_n[0] - m0, 2);
        chk("abort.we", we_hi[0] - w0, 4);
        chk("abort.bwe", bwe_n[0] - b0, 0);
        chk("abort.d1", mapw[0][1], bufr[0][1]);

        for (int i = 0; i < 4; i++) begin
            fill_rand(0);
            sweep(0, 1'($urandom), 1'b0, 1'($urandom),
                  $sformatf("rnd%0d", i));
        end

        d0 = done_n[1];
        st_l[1] = 1'b1;
        tick;
        st_l[1] = 1'b0;
        n = 0;
        while (addr[1] != 8'd64 && n < 400) begin
            tick;
            n++;
        end
        chk("rst.reach", 32'(n < 400), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst.async",
            {act[1], we[1], m2[1], addr[1], wdat[1], bwe[1], busy[1], done[1]},
            {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        tick;
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        chk("rst.nodone", done_n[1] - d0, 0);
        fill_rand(1);
        sweep(1, 1'b0, 1'b0, 1'b0, "rst.save");

        fill_rand(2);
        sweep(2, 1'b0, 1'b0, 1'b0, "big");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/ss_sweep_master.md
SS_SWEEP_MASTER -- requirements
Module: ss_sweep_master

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 127, the final save-state register address swept (inclusive, range 0..255).
REQ-002 SHALL have port clk, input, 1, system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_save, input, 1, one-cycle request to copy mapper registers into the buffer.
REQ-005 SHALL have port start_load, input, 1, one-cycle request to restore mapper registers from the buffer.
REQ-006 SHALL have port abort, input, 1, terminates any sweep in progress.
REQ-007 SHALL have port ss_act, output, 1, save-state access active towards the mapper.
REQ-008 SHALL have port ss_we, output, 1, save-state write strobe towards the mapper.
REQ-009 SHALL have port ss_addr, output, 8, mapper save-state register address.
REQ-010 SHALL have port ss_wdat, output, 8, restore data driven onto the mapper CPU data bus.
REQ-011 SHALL have port ss_m2, output, 1, generated M2 strobe; the mapper latches on its falling edge.
REQ-012 SHALL have port ss_rdat, input, 8, mapper readback data for ss_addr.
REQ-013 SHALL have ports buf_addr, output, 8; buf_wdat, output, 8; buf_we, output, 1: the buffer write port.
REQ-014 SHALL have port buf_rdat, input, 8, buffer read data, valid one clk after buf_addr is presented.
REQ-015 SHALL have ports busy, output, 1, and done, output, 1: sweep in progress, and a one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, SETUP, SAMPLE, STROBE, NEXT and DONE, with a mode bit (save or load) latched at start.
REQ-017 In IDLE, SHALL move to SETUP with ss_addr=0 on start_save or start_load; when both are asserted, save SHALL win.
REQ-018 SHALL ignore start_save and start_load while busy=1.
REQ-019 SETUP: ss_act=1, ss_m2=1, ss_we=0, and buf_addr=ss_addr issued so that the buffer read is available in SAMPLE.
REQ-020 SAMPLE (save mode): ss_m2=1, ss_we=0, buf_we=1, buf_wdat=ss_rdat, buf_addr=ss_addr.
REQ-021 SAMPLE (load mode): ss_m2=1, ss_we=1, ss_wdat=buf_rdat, registered and held through STROBE and NEXT.
REQ-022 STROBE: ss_m2=0, which produces exactly one falling edge per address; in load mode ss_we=1 and ss_wdat SHALL stay stable.
REQ-023 NEXT: ss_m2=0 and ss_we=0; if ss_addr==LAST_ADDR go to DONE, else increment ss_addr by 1 and go to SETUP.
REQ-024 ss_addr SHALL NOT wrap; with LAST_ADDR=255 the sweep SHALL end at 255 without an 8-bit overflow.
REQ-025 DONE: done=1 for exactly one clk, ss_act=0, then IDLE; the full sweep SHALL take 4*(LAST_ADDR+1)+1 clk from start acceptance to the done pulse.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 abort in any non-IDLE state SHALL go to IDLE on the next clk with ss_act=0, ss_we=0, ss_m2=1 and buf_we=0, and SHALL NOT pulse done; a write already strobed stays committed.
REQ-028 buf_we SHALL never assert in load mode, and ss_we SHALL never assert in save mode.
REQ-029 ss_we and ss_wdat SHALL NOT change while ss_m2 falls, giving setup/hold of at least one clk around the edge.

Reset
REQ-030 On rst_n=0, all outputs SHALL be forced immediately: state=IDLE, ss_act=0, ss_we=0, ss_m2=1, ss_addr=0, ss_wdat=0, buf_we=0, busy=0, done=0.
REQ-031 Reset mid-sweep SHALL abandon the sweep without a done pulse; the first start after release SHALL begin again at address 0.

Verification
REQ-032 Save, LAST_ADDR=2, mapper model returns 8'h05, 8'h0A, 8'h01 -> buffer[0..2]=05,0A,01; done pulses at clk 13; no ss_we ever asserted.
REQ-033 Load, buffer[0..2]=8'hF3,8'h07,8'h01 -> mapper sees three ss_m2 falling edges with ss_we=1 and data F3,07,01 at addresses 0,1,2; done pulses once.
REQ-034 start_save and start_load asserted in the same clk -> save sweep runs; a start_load pulsed mid-sweep is ignored.
REQ-035 abort during STROBE at address 1 -> IDLE next clk, ss_act=0, no done, no further buf_we or ss_we.
REQ-036 rst_n pulsed low during load at address 64 (LAST_ADDR=127) -> outputs take reset values asynchronously; the next start_save begins at ss_addr=0.
REQ-037 LAST_ADDR=255 save -> 256 buffer writes, final ss_addr=255, no wrap to 0, done at clk 1025.
